// File: rtl/inst_fetch_queue_if.sv
// Fetch/decode handshake bundle for the instruction fetch queue.
// The master side is the fetcher plus decode. The slave side is the queue.
interface inst_fetch_queue_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic              fetch_valid;
  logic [63:0]       fetch_addr;
  logic [63:0]       fetch_data;
  logic              fetch_ready;
  logic              flush;
  logic              dec_valid;
  logic [31:0]       dec_instr;
  logic [63:0]       dec_pc;
  logic              dec_misaligned;
  logic              dec_ready;
  logic [PTR_W:0]    count;

  modport master (
    output fetch_valid, fetch_addr, fetch_data, flush, dec_ready,
    input  fetch_ready, dec_valid, dec_instr, dec_pc, dec_misaligned, count
  );

  modport slave (
    input  fetch_valid, fetch_addr, fetch_data, flush, dec_ready,
    output fetch_ready, dec_valid, dec_instr, dec_pc, dec_misaligned, count
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: buffers up to DEPTH (pc, instr, misaligned)
// entries between the fetcher and decode, with a single-cycle flush.
module inst_fetch_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  inst_fetch_queue_if.slave  bus
);
  localparam int unsigned      PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        misaligned;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} occ_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count_q;
  occ_t             occ;
  logic             push;
  logic             pop;
  logic             wr_en;
  entry_t           new_entry;

  // Occupancy is derived from the registered count only.
  always_comb begin
    occ = PARTIAL;
    if (count_q == '0)
      occ = EMPTY;
    else if (count_q == FULL_CNT)
      occ = FULL;
  end

  // Handshakes and the entry built from the incoming 64-bit fetch word.
  always_comb begin
    bus.fetch_ready      = (occ != FULL);
    bus.dec_valid        = (occ != EMPTY);
    push                 = bus.fetch_valid & bus.fetch_ready;
    pop                  = bus.dec_valid & bus.dec_ready;
    wr_en                = push & ~bus.flush;
    new_entry.pc         = bus.fetch_addr;
    new_entry.instr      = bus.fetch_addr[2] ? bus.fetch_data[63:32]
                                             : bus.fetch_data[31:0];
    new_entry.misaligned = |bus.fetch_addr[1:0];
  end

  // Head read: combinational view of registered storage.
  always_comb begin
    bus.dec_pc         = mem[rd_ptr].pc;
    bus.dec_instr      = mem[rd_ptr].instr;
    bus.dec_misaligned = mem[rd_ptr].misaligned;
    bus.count          = count_q;
  end

  // Entry storage. Reset clears it. A flush leaves the contents in place.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_ptr] <= new_entry;
    end
  end

  // Pointers and count. A flush overrides any concurrent push or pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else if (bus.flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule
